// File: rtl/hub_pkg.sv
// Shared constants and state encodings for the serial broadcast hub.
// Build option: HUB_PARITY_EN adds one even-parity bit per frame.
package hub_pkg;

  localparam logic [7:0] SFD = 8'b1010_1011;

  typedef enum logic [1:0] {
    RX_HUNT,
    RX_DATA,
    RX_PAR
  } rx_st_t;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_SFD,
    TX_DATA,
    TX_PAR,
    TX_GAP
  } tx_st_t;

endpackage

// File: rtl/hub_rx_port.sv
// One rx lane: SFD hunt, deserialiser, optional parity check, frame FIFO.
// Build option: HUB_PARITY_EN enables the parity bit after the payload.
module hub_rx_port
  import hub_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rx,
  input  logic              pop,
  output logic              empty,
  output logic [DATA_W-1:0] frame_out,
  output logic              drop
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(DATA_W) + 1;
`ifdef HUB_PARITY_EN
  localparam rx_st_t RX_AFTER = RX_PAR;
  localparam bit     PAR_EN   = 1'b1;
`else
  localparam rx_st_t RX_AFTER = RX_HUNT;
  localparam bit     PAR_EN   = 1'b0;
`endif

  rx_st_t            r_st, w_st_nx;
  logic [7:0]        r_shift;
  logic [7:0]        w_shift_nx;
  logic [BW-1:0]     r_cnt;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] w_data_nx;
  logic              r_pend, r_drop;
  logic              w_hit, w_last, w_pend_set;
  logic              w_bad, w_full, w_push, w_pop;
  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wp, r_rp;
  logic [AW:0]       r_count;

  assign w_shift_nx = {r_shift[6:0], rx};
  assign w_data_nx  = (r_data << 1) | DATA_W'(rx);
  assign w_hit      = (r_st == RX_HUNT) && (w_shift_nx == SFD);
  assign w_last     = (r_st == RX_DATA) &&
                      (r_cnt == BW'(DATA_W - 1));
  assign w_pend_set = PAR_EN ? (r_st == RX_PAR) : w_last;

  always_comb begin
    w_st_nx = r_st;
    unique case (r_st)
      RX_HUNT: if (w_hit) w_st_nx = RX_DATA;
      RX_DATA: if (w_last) w_st_nx = RX_AFTER;
      default: w_st_nx = RX_HUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) r_st <= RX_HUNT;
    else          r_st <= w_st_nx;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_shift <= '0;
      r_cnt   <= '0;
      r_data  <= '0;
      r_pend  <= 1'b0;
    end else begin
      r_pend <= w_pend_set;
      if (r_st == RX_HUNT) begin
        r_shift <= w_hit ? 8'h00 : w_shift_nx;
        r_cnt   <= '0;
      end else if (r_st == RX_DATA) begin
        r_data <= w_data_nx;
        r_cnt  <= r_cnt + 1'b1;
      end
    end
  end

`ifdef HUB_PARITY_EN
  logic r_bad;
  always_ff @(posedge clk) begin
    if (!reset_n) r_bad <= 1'b0;
    else          r_bad <= (r_st == RX_PAR) && (^{r_data, rx});
  end
  assign w_bad = r_bad;
`else
  assign w_bad = 1'b0;
`endif

  // Full is judged on the count before any same-cycle pop.
  assign w_full = (r_count == (AW + 1)'(FIFO_DEPTH));
  assign w_push = r_pend && !w_bad && !w_full;
  assign w_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= r_data;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
      r_drop  <= 1'b0;
    end else begin
      r_drop <= r_pend && (w_bad || w_full);
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign empty     = (r_count == '0);
  assign frame_out = r_mem[r_rp];
  assign drop      = r_drop;

endmodule

// File: rtl/serial_hub.sv
// N-port serial broadcast hub: per-port rx FIFOs, round-robin tx.
// Build option: HUB_PARITY_EN appends even parity on every tx frame.
module serial_hub
  import hub_pkg::*;
#(
  parameter int NPORTS     = 3,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int IFG_CYC    = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NPORTS-1:0] rx,
  output logic [NPORTS-1:0] tx,
  output logic              busy,
  output logic [NPORTS-1:0] drop
);

  localparam int PW   = $clog2(NPORTS);
  localparam int CMAX = (IFG_CYC > 32) ? IFG_CYC : 32;
  localparam int CW   = $clog2(CMAX + 1);
`ifdef HUB_PARITY_EN
  localparam tx_st_t TX_AFTER = TX_PAR;
`else
  localparam tx_st_t TX_AFTER = TX_GAP;
`endif

  logic [NPORTS-1:0] w_empty, w_pop;
  logic [DATA_W-1:0] w_frame [NPORTS];

  for (genvar g = 0; g < NPORTS; g++) begin : g_rx
    hub_rx_port #(
      .DATA_W    (DATA_W),
      .FIFO_DEPTH(FIFO_DEPTH)
    ) u_rx (
      .clk      (clk),
      .reset_n  (reset_n),
      .rx       (rx[g]),
      .pop      (w_pop[g]),
      .empty    (w_empty[g]),
      .frame_out(w_frame[g]),
      .drop     (drop[g])
    );
  end

  tx_st_t            r_st, w_st_nx;
  logic [CW-1:0]     r_cnt;
  logic [PW-1:0]     r_rr, r_src, w_gnt, w_rr_nx;
  logic [DATA_W-1:0] r_sh;
  logic [NPORTS-1:0] r_tx, w_src_oh;
  logic              w_found, w_grant, w_on, w_bit, w_par;

  // Scan downward so the nearest non-empty port above rr_ptr wins.
  always_comb begin
    w_found = 1'b0;
    w_gnt   = r_rr;
    for (int i = NPORTS - 1; i >= 0; i--) begin
      if (!w_empty[(int'(r_rr) + i) % NPORTS]) begin
        w_found = 1'b1;
        w_gnt   = PW'((int'(r_rr) + i) % NPORTS);
      end
    end
  end

  assign w_grant  = (r_st == TX_IDLE) && w_found;
  assign w_pop    = w_grant ? (NPORTS'(1) << w_gnt) : '0;
  assign w_rr_nx  = (w_gnt == PW'(NPORTS - 1)) ? '0 : w_gnt + 1'b1;
  assign w_src_oh = NPORTS'(1) << r_src;

  always_comb begin
    w_st_nx = r_st;
    w_on    = 1'b0;
    w_bit   = 1'b0;
    unique case (r_st)
      TX_IDLE: if (w_found) w_st_nx = TX_SFD;
      TX_SFD: begin
        w_on  = 1'b1;
        w_bit = SFD[3'd7 - r_cnt[2:0]];
        if (r_cnt == CW'(7)) w_st_nx = TX_DATA;
      end
      TX_DATA: begin
        w_on  = 1'b1;
        w_bit = r_sh[DATA_W-1];
        if (r_cnt == CW'(DATA_W - 1)) w_st_nx = TX_AFTER;
      end
      TX_PAR: begin
        w_on    = 1'b1;
        w_bit   = w_par;
        w_st_nx = TX_GAP;
      end
      TX_GAP: if (r_cnt == CW'(IFG_CYC - 1)) w_st_nx = TX_IDLE;
      default: w_st_nx = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) r_st <= TX_IDLE;
    else          r_st <= w_st_nx;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt <= '0;
      r_rr  <= '0;
      r_src <= '0;
      r_sh  <= '0;
      r_tx  <= '0;
    end else begin
      r_cnt <= (w_st_nx != r_st) ? '0 : r_cnt + 1'b1;
      r_tx  <= w_on ? ({NPORTS{w_bit}} & ~w_src_oh) : '0;
      if (w_grant) begin
        r_src <= w_gnt;
        r_sh  <= w_frame[w_gnt];
        r_rr  <= w_rr_nx;
      end else if (r_st == TX_DATA) begin
        r_sh <= r_sh << 1;
      end
    end
  end

`ifdef HUB_PARITY_EN
  logic r_par;
  always_ff @(posedge clk) begin
    if (!reset_n)     r_par <= 1'b0;
    else if (w_grant) r_par <= ^w_frame[w_gnt];
  end
  assign w_par = r_par;
`else
  assign w_par = 1'b0;
`endif

  assign tx   = r_tx;
  assign busy = (r_st != TX_IDLE);

endmodule

// File: tb/tb_serial_hub.sv
// Directed bench for serial_hub: decodes every tx lane into frame events.
// Build option: HUB_PARITY_EN also exercises the parity path.
module tb_serial_hub;

  localparam int NP  = 3;
  localparam int DW  = 8;
  localparam int FD  = 4;
  localparam int IFG = 20;
`ifdef HUB_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FLEN = 8 + DW + PB;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [NP-1:0] rx = '0;
  logic [NP-1:0] tx, drop;
  logic          busy;

  serial_hub #(
    .NPORTS(NP), .DATA_W(DW),
    .FIFO_DEPTH(FD), .IFG_CYC(IFG)
  ) dut (
    .clk(clk), .reset_n(reset_n), .rx(rx),
    .tx(tx), .busy(busy), .drop(drop)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  logic rst_seen = 1'b1;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rst_seen <= !reset_n;

  typedef struct {
    int port;
    int data;
    int par;
    int start;
  } ev_t;
  ev_t evq[$];
  int  dcnt [NP];

  logic [7:0] dsh [NP];
  int dst [NP], dn [NP], ddat [NP], dpar [NP], dstart [NP];

  // Reference receiver on each tx lane; start = cycle of first SFD bit.
  always @(negedge clk) begin
    for (int i = 0; i < NP; i++) begin
      if (drop[i]) dcnt[i] = dcnt[i] + 1;
      if (rst_seen) begin
        dst[i] = 0;
        dsh[i] = 8'h00;
      end else if (dst[i] == 0) begin
        dsh[i] = {dsh[i][6:0], tx[i]};
        if (dsh[i] == 8'hAB) begin
          dst[i] = 1; dn[i] = 0; ddat[i] = 0;
          dpar[i] = 0; dstart[i] = cyc - 7;
          dsh[i] = 8'h00;
        end
      end else begin
        if (dn[i] < DW) ddat[i] = (ddat[i] << 1) | int'(tx[i]);
        else            dpar[i] = int'(tx[i]);
        dn[i] = dn[i] + 1;
        if (dn[i] == DW + PB) begin
          evq.push_back('{i, ddat[i], dpar[i], dstart[i]});
          dst[i] = 0;
        end
      end
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic chk_ev(input string nm, input int i,
                        input int port, input int data, input int start);
    ev_t e;
    logic [7:0] d8;
    if (i < evq.size()) e = evq[i];
    else e = '{-1, -1, -1, -1};
    d8 = data[7:0];
    chk({nm, ".port"}, e.port, port);
    chk({nm, ".data"}, e.data, data);
    chk({nm, ".start"}, e.start, start);
    if (PB != 0) chk({nm, ".par"}, e.par, int'(^d8));
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_raw(input int p, input logic [31:0] b,
                          input int n, output int k);
    for (int i = n - 1; i >= 0; i--) begin
      @(negedge clk);
      rx[p] = b[i];
    end
    k = cyc + 1;
  endtask

  task automatic send(input int p, input logic [7:0] d,
                      input logic flip, output int k);
    logic [31:0] b;
    int n;
    b = {16'h0000, 8'hAB, d};
    n = 16;
    if (PB != 0) begin
      b = {b[30:0], (^d) ^ flip};
      n = 17;
    end
    send_raw(p, b, n, k);
  endtask

  task automatic rx_idle(input int p);
    @(negedge clk);
    rx[p] = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  typedef struct {
    int         src;
    logic [7:0] data;
    int         d0;
    int         d1;
  } vec_t;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt [5];
    int   base, k, k0, k1, k2, d0, d1, d2;
    int   l0 [$], l1 [$];
    int   exp3 [5];
    vt[0] = '{0, 8'hF0, 1, 2};
    vt[1] = '{1, 8'hCC, 0, 2};
    vt[2] = '{2, 8'h5A, 0, 1};
    vt[3] = '{0, 8'h00, 1, 2};
    vt[4] = '{2, 8'hFF, 0, 1};

    wait_cyc(3);
    chk("rst.tx", int'(tx), 0);
    chk("rst.busy", int'(busy), 0);
    chk("rst.drop", int'(drop), 0);
    reset_n = 1'b1;
    wait_cyc(12);

    for (int v = 0; v < 5; v++) begin
      base = evq.size();
      send(vt[v].src, vt[v].data, 1'b0, k);
      rx_idle(vt[v].src);
      wait_cyc(45);
      chk($sformatf("vec%0d.count", v), evq.size() - base, 2);
      chk_ev($sformatf("vec%0d.e0", v), base, vt[v].d0,
             int'(vt[v].data), k + 3);
      chk_ev($sformatf("vec%0d.e1", v), base + 1, vt[v].d1,
             int'(vt[v].data), k + 3);
    end

    base = evq.size();
    fork
      begin send(0, 8'hF0, 1'b0, k0); rx_idle(0); end
      begin send(1, 8'hCC, 1'b0, k1); rx_idle(1); end
    join
    wait_cyc(90);
    k2 = k0 + 3 + FLEN + IFG + 1;
    chk("arb.count", evq.size() - base, 4);
    chk_ev("arb.p0a", base,     1, 8'hF0, k0 + 3);
    chk_ev("arb.p0b", base + 1, 2, 8'hF0, k0 + 3);
    chk_ev("arb.p1a", base + 2, 0, 8'hCC, k2);
    chk_ev("arb.p1b", base + 3, 2, 8'hCC, k2);
    chk("arb.rr_ptr", int'(dut.r_rr), 2);

    pulse_reset();
    wait_cyc(2);
    base = evq.size();
    d0 = dcnt[0]; d1 = dcnt[1]; d2 = dcnt[2];
    fork
      begin send(0, 8'h11, 1'b0, k); rx_idle(0); end
      begin send(1, 8'h22, 1'b0, k1); rx_idle(1); end
      begin
        for (int j = 0; j < FD + 1; j++)
          send(2, 8'h31 + 8'(j), 1'b0, k2);
        rx_idle(2);
      end
    join
    wait_cyc(240);
    chk("ovf.drop2", dcnt[2] - d2, 1);
    chk("ovf.drop0", dcnt[0] - d0, 0);
    chk("ovf.drop1", dcnt[1] - d1, 0);
    chk("ovf.count", evq.size() - base, 2 * (FD + 2));
    for (int i = base; i < evq.size(); i++) begin
      if (evq[i].port == 0) l0.push_back(evq[i].data);
      if (evq[i].port == 1) l1.push_back(evq[i].data);
    end
    exp3 = '{8'h11, 8'h31, 8'h32, 8'h33, 8'h34};
    chk("ovf.tx1.len", l1.size(), 5);
    chk("ovf.tx0.len", l0.size(), 5);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("ovf.tx1[%0d]", i),
          (i < l1.size()) ? l1[i] : -1, exp3[i]);
      chk($sformatf("ovf.tx0[%0d]", i),
          (i < l0.size()) ? l0[i] : -1,
          (i == 0) ? 8'h22 : exp3[i]);
    end

    base = evq.size();
    send_raw(0, {8'h00, 12'b1010_1010_1011, 8'hA5, 4'h0},
             20, k);
    k = k - 4;
    wait_cyc(45);
    chk("fs.count", evq.size() - base, 2);
    chk_ev("fs.e0", base,     1, 8'hA5, k + 3);
    chk_ev("fs.e1", base + 1, 2, 8'hA5, k + 3);

    base = evq.size();
    send(0, 8'h3C, 1'b0, k);
    rx_idle(0);
    while (cyc < k + 13) @(negedge clk);
    chk("mid.busy_before", int'(busy), 1);
    reset_n = 1'b0;
    @(negedge clk);
    chk("mid.tx", int'(tx), 0);
    chk("mid.busy", int'(busy), 0);
    reset_n = 1'b1;
    wait_cyc(40);
    chk("mid.abandoned", evq.size() - base, 0);
    base = evq.size();
    send(2, 8'h96, 1'b0, k);
    rx_idle(2);
    wait_cyc(45);
    chk("post.count", evq.size() - base, 2);
    chk_ev("post.e0", base,     0, 8'h96, k + 3);
    chk_ev("post.e1", base + 1, 1, 8'h96, k + 3);

`ifdef HUB_PARITY_EN
    base = evq.size();
    d0 = dcnt[0];
    send(0, 8'hF0, 1'b1, k);
    rx_idle(0);
    wait_cyc(45);
    chk("par.bad.drop", dcnt[0] - d0, 1);
    chk("par.bad.count", evq.size() - base, 0);
    base = evq.size();
    send(0, 8'hF0, 1'b0, k);
    rx_idle(0);
    wait_cyc(45);
    chk("par.ok.count", evq.size() - base, 2);
    chk_ev("par.ok.e0", base,     1, 8'hF0, k + 3);
    chk_ev("par.ok.e1", base + 1, 2, 8'hF0, k + 3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
